// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
// Scans a 4x4 active-low matrix keypad one column at a time, debounces whole
// frames and reports new presses.
//
// Ports:
//   clk        system clock
//   nrst       asynchronous active-low reset
//   col[3:0]   column drive, active-low one-hot (1110, 1101, 1011, 0111, ...)
//   row[3:0]   row sense, active-low, asynchronous to clk
//   psw[15:0]  debounced key vector, bit = col_idx*4 + row_idx, 1 = pressed
//   key_code   lowest pressed index captured at the press event
//   key_valid  one-cycle pulse when psw goes from zero to non-zero
//   key_held   high while the committed psw is non-zero
module keypad_scan_ctrl #(
   parameter int unsigned SCAN_DIV       = 1000,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic        clk,
   input  logic        nrst,
   output logic [3:0]  col,
   input  logic [3:0]  row,
   output logic [15:0] psw,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic        key_held
);

   localparam int unsigned CW = $clog2(SCAN_DIV);
   localparam int unsigned MW = $clog2(DEBOUNCE_SCANS) + 1;
   localparam logic [CW-1:0] DwellLast = CW'(SCAN_DIV - 1);
   localparam logic [MW-1:0] MatchLast = MW'(DEBOUNCE_SCANS - 1);

   typedef enum logic {StIdle, StHeld} state_e;

   logic [3:0]    r_row_meta;
   logic [3:0]    r_row_s;
   logic [CW-1:0] r_dwell;
   logic [1:0]    r_col_idx;
   logic [11:0]   r_frame_lo;   // columns 0..2 of the frame in progress
   logic [15:0]   r_frame_prev;
   logic [MW-1:0] r_match;
   logic [15:0]   r_psw;
   logic [3:0]    r_key_code;
   logic          r_key_valid;
   state_e        r_state;

   logic          w_sample;
   logic          w_frame_end;
   logic [15:0]   w_frame;
   logic [MW-1:0] w_match_d;
   logic          w_commit;
   state_e        w_state_d;
   logic          w_valid_d;
   logic [3:0]    w_code_d;

   function automatic logic [3:0] f_lowest(input logic [15:0] v);
      logic [3:0] res;
      res = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) res = 4'(i);
      end
      return res;
   endfunction

   // Row synchronizer, idle level is all-ones (no key).
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_row_meta <= 4'b1111;
         r_row_s    <= 4'b1111;
      end else begin
         r_row_meta <= row;
         r_row_s    <= r_row_meta;
      end
   end

   assign w_sample    = (r_dwell == DwellLast);
   assign w_frame_end = w_sample && (r_col_idx == 2'd3);
   // Completed frame: last column comes straight from the synchronizer.
   assign w_frame     = {~r_row_s, r_frame_lo};

   always_comb begin
      w_match_d = '0;
      if (w_frame == r_frame_prev) begin
         w_match_d = (r_match == MatchLast) ? r_match : r_match + MW'(1);
      end
   end

   assign w_commit = w_frame_end && (w_match_d == MatchLast);

   // Scan, sampling and debounce datapath.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_dwell      <= '0;
         r_col_idx    <= 2'd0;
         r_frame_lo   <= '0;
         r_frame_prev <= '0;
         r_match      <= '0;
         r_psw        <= '0;
      end else begin
         if (w_sample) begin
            r_dwell   <= '0;
            r_col_idx <= r_col_idx + 2'd1;
            case (r_col_idx)
               2'd0:    r_frame_lo[3:0]  <= ~r_row_s;
               2'd1:    r_frame_lo[7:4]  <= ~r_row_s;
               2'd2:    r_frame_lo[11:8] <= ~r_row_s;
               default: begin
                  r_match      <= w_match_d;
                  r_frame_prev <= w_frame;
                  if (w_commit) r_psw <= w_frame;
               end
            endcase
         end else begin
            r_dwell <= r_dwell + CW'(1);
         end
      end
   end

   // Press FSM: state register.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state     <= StIdle;
         r_key_valid <= 1'b0;
         r_key_code  <= 4'd0;
      end else begin
         r_state     <= w_state_d;
         r_key_valid <= w_valid_d;
         r_key_code  <= w_code_d;
      end
   end

   // Press FSM: next state, driven by the value being committed.
   always_comb begin
      w_state_d = r_state;
      if (w_commit) begin
         w_state_d = (w_frame != 16'd0) ? StHeld : StIdle;
      end
   end

   // Press FSM: outputs; the pulse and code land together with the new psw.
   always_comb begin
      w_valid_d = (r_state == StIdle) && w_commit && (w_frame != 16'd0);
      w_code_d  = w_valid_d ? f_lowest(w_frame) : r_key_code;
   end

   assign col       = ~(4'b0001 << r_col_idx);
   assign psw       = r_psw;
   assign key_code  = r_key_code;
   assign key_valid = r_key_valid;
   assign key_held  = (r_state == StHeld);

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Scans a 4x4 matrix keypad by driving one active-low column at a time and sampling the active-low rows.
- Builds a debounced 16-bit key-state vector from the scans.
- Emits a single-cycle event with the encoded key code on each new press.
- Sits between the keypad pins and the key-entry/encoder logic, and supplies the psw-style vector consumed downstream.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven (dwell). Legal range ≥ 4.
- DEBOUNCE_SCANS, 4: consecutive identical full frames required before the key vector is committed. Legal range ≥ 1.

Ports:
- clk  in  1  system clock
- nrst  in  1  reset, asynchronous, active-low
- col  out  4  column drive, active-low one-hot
- row  in  4  row sense, active-low (external pull-ups), asynchronous to clk
- psw  out  16  debounced key vector; bit index = col_idx*4 + row_idx; 1 = pressed
- key_code  out  4  index of the lowest set psw bit at the moment of the press event
- key_valid  out  1  one-cycle pulse on a new press (psw goes from zero to non-zero)
- key_held  out  1  high while the committed psw is non-zero

Behaviour:
- Reset (nrst low, asynchronous):
  - col=4'b1110, psw=0, key_code=0, key_valid=0, key_held=0.
  - Dwell counter, column index, frame_cur, frame_prev and match_cnt cleared.
  - Row synchronizer flops set to 4'b1111.
- Synchronizer: row passes through a 2-flop synchronizer, giving row_s.
- Column scan:
  - Dwell counter counts 0..SCAN_DIV-1 and wraps.
  - On wrap, the column index advances 0→1→2→3→0.
  - col = ~(1 << col_idx). Sequence is 1110, 1101, 1011, 0111, repeating.
  - One frame = 4*SCAN_DIV cycles.
- Sampling:
  - Sample at dwell count SCAN_DIV-1 only. This lets the pins settle and the synchronizer fill.
  - frame_cur[col_idx*4 + r] <= ~row_s[r] for r = 0..3.
- Frame end (sample of col_idx 3), all updates in the same edge:
  - If the completed frame equals frame_prev: match_cnt <= min(match_cnt+1, DEBOUNCE_SCANS-1). Otherwise match_cnt <= 0.
  - frame_prev <= completed frame.
  - If the updated match_cnt == DEBOUNCE_SCANS-1: psw <= completed frame (commit).
  - With DEBOUNCE_SCANS=1, every frame commits.
- Press FSM (states IDLE, HELD), evaluated on the committed psw:
  - IDLE: on a commit with psw≠0, go to HELD.
    - In the cycle after the commit: key_valid=1 for exactly one cycle.
    - key_code = lowest set index, key_held=1.
  - HELD: additional keys and partial releases update psw only. No key_valid, and key_code is unchanged (no rollover).
  - HELD: on a commit with psw==0, go to IDLE and set key_held=0. key_code holds its last value; no pulse on release.
- Latency: from a stable press to key_valid is DEBOUNCE_SCANS to DEBOUNCE_SCANS+1 frames, plus sync/commit cycles.
- Boundaries:
  - A bounce in any frame resets match_cnt, so there is no commit.
  - A chord (simultaneous keys) yields the lowest index.
  - Counters wrap without gaps.
  - Reset mid-press returns all outputs to reset values immediately. A key still held after reset deasserts is detected as a new press after debounce.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3; frame = 16 cycles; bench keypad model pulls row r low while the column of a pressed key is driven low):
1. Reset, then run 20 cycles with no keys -> all outputs 0; col steps 1110→1101→1011→0111→1110 every 4 cycles; no key_valid.
2. Hold key 9 (col 2, row 1) -> within 4 frames: psw=16'h0200, exactly one key_valid pulse, key_code=9, key_held=1; no further pulses over 10 more frames.
3. Release key 9 -> within 4 frames: psw=0, key_held=0, no key_valid, key_code stays 9.
4. Key 5 toggled pressed/released on alternate frames for 8 frames -> psw stays 0, key_valid never asserts.
5. Press keys 3 and 12 together -> psw=16'h1008, one pulse, key_code=3. Then release key 3 -> psw=16'h1000, no pulse, key_code=3, key_held=1.
6. Key 0 held; pulse nrst low mid-frame for 3 cycles -> outputs clear immediately and col=1110. After reset deasserts with key 0 still held -> psw=16'h0001, one key_valid pulse, key_code=0.
